// File: rtl/opb_sw_reg_pkg.sv
// Shared constants, decode record and OPB bit-order helpers for the
// software register bank.
package opb_sw_reg_pkg;

  localparam int WORD_W     = 32;
  localparam int BYTE_W     = 8;
  localparam int WORD_BYTES = WORD_W / BYTE_W;
  localparam int CNT_W      = 16;

  localparam int CTRL_COMMIT  = 0;
  localparam int CTRL_AUTO    = 1;
  localparam int CTRL_CNT_LSB = 16;

  typedef struct packed {
    logic shadow;
    logic ctrl;
    logic stat0;
    logic stat;
    logic err;
  } dec_t;

  // OPB numbers bit 0 as the MSB; fabric side uses [31:0].
  function automatic logic [WORD_W-1:0] opb_to_le(input logic [0:WORD_W-1] d);
    logic [WORD_W-1:0] r;
    for (int i = 0; i < WORD_W; i++) r[WORD_W-1-i] = d[i];
    return r;
  endfunction

  function automatic logic [WORD_BYTES-1:0] opb_be_to_le(input logic [0:WORD_BYTES-1] be);
    logic [WORD_BYTES-1:0] r;
    for (int i = 0; i < WORD_BYTES; i++) r[WORD_BYTES-1-i] = be[i];
    return r;
  endfunction

  function automatic logic [WORD_W-1:0] be_mask(input logic [WORD_BYTES-1:0] be);
    logic [WORD_W-1:0] m;
    for (int i = 0; i < WORD_BYTES; i++) m[i*BYTE_W +: BYTE_W] = {BYTE_W{be[i]}};
    return m;
  endfunction

endpackage

// File: rtl/opb_slave_ack.sv
// OPB slave handshake: one registered ack per select assertion, one cycle
// after select is first seen; re-armed only once select drops.
module opb_slave_ack (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_select,
  input  logic i_hit,
  input  logic i_err,
  output logic o_start,
  output logic o_xfer_ack,
  output logic o_err_ack
);

  logic r_done;
  logic r_xfer;
  logic r_err;

  assign o_start    = i_select & i_hit & ~r_done;
  assign o_xfer_ack = r_xfer;
  assign o_err_ack  = r_err;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_done <= 1'b0;
      r_xfer <= 1'b0;
      r_err  <= 1'b0;
    end else begin
      r_xfer <= o_start & ~i_err;
      r_err  <= o_start & i_err;
      r_done <= i_select & (r_done | o_start);
    end
  end

endmodule

// File: rtl/opb_sw_reg_bank.sv
// Multi-word OPB software register bank: shadowed control words with atomic
// commit, CTRL register, and coherent status snapshot.
module opb_sw_reg_bank
  import opb_sw_reg_pkg::*;
#(
  parameter logic [31:0] C_BASEADDR   = 32'h0000_0000,
  parameter logic [31:0] C_HIGHADDR   = 32'h0000_00FF,
  parameter int          C_OPB_AWIDTH = 32,
  parameter int          C_OPB_DWIDTH = 32,
  parameter              C_FAMILY     = "virtex6",
  parameter int          NUM_REGS     = 4,
  parameter int          NUM_STAT     = 2,
  parameter logic [31:0] RESET_VAL    = 32'h0
) (
  input  logic                         OPB_Clk,
  input  logic                         OPB_Rst,
  input  logic [0:C_OPB_AWIDTH-1]      OPB_ABus,
  input  logic [0:C_OPB_DWIDTH/8-1]    OPB_BE,
  input  logic [0:C_OPB_DWIDTH-1]      OPB_DBus,
  input  logic                         OPB_RNW,
  input  logic                         OPB_select,
  input  logic                         OPB_seqAddr,
  output logic [0:C_OPB_DWIDTH-1]      Sl_DBus,
  output logic                         Sl_errAck,
  output logic                         Sl_retry,
  output logic                         Sl_toutSup,
  output logic                         Sl_xferAck,
  output logic [NUM_REGS*WORD_W-1:0]   user_data_out,
  output logic                         user_commit,
  input  logic [NUM_STAT*WORD_W-1:0]   user_data_in
);

  localparam logic [29:0] K_CTRL = 30'(NUM_REGS);
  localparam logic [29:0] K_LAST = 30'(NUM_REGS + NUM_STAT);

  logic [NUM_REGS-1:0][WORD_W-1:0] r_shadow;
  logic [NUM_REGS-1:0][WORD_W-1:0] r_active;
  logic [NUM_STAT-1:0][WORD_W-1:0] r_snap;
  logic [NUM_STAT-1:0][WORD_W-1:0] w_stat;
  logic                            r_auto;
  logic [CNT_W-1:0]                r_cnt;
  logic                            r_commit_req;
  logic                            r_commit;
  logic [WORD_W-1:0]               r_rdata;

  logic [WORD_W-1:0]     w_addr;
  logic [WORD_W-1:0]     w_off;
  logic [WORD_W-1:0]     w_wdata;
  logic [WORD_W-1:0]     w_mask;
  logic [WORD_W-1:0]     w_rdata;
  logic [WORD_W-1:0]     w_ctrl;
  logic [29:0]           w_k;
  logic [WORD_BYTES-1:0] w_be;
  logic                  w_hit;
  logic                  w_start;
  logic                  w_wr;
  logic                  w_rd;
  logic                  w_xfer_ack;
  logic                  w_err_ack;
  logic                  w_unused;
  dec_t                  w_dec;

  assign w_addr  = opb_to_le(OPB_ABus);
  assign w_wdata = opb_to_le(OPB_DBus);
  assign w_be    = opb_be_to_le(OPB_BE);
  assign w_mask  = be_mask(w_be);
  assign w_off   = w_addr - C_BASEADDR;
  assign w_k     = w_off[31:2];
  assign w_hit   = OPB_select && (w_addr >= C_BASEADDR) && (w_addr <= C_HIGHADDR);
  assign w_stat  = user_data_in;

  always_comb begin
    w_dec        = '0;
    w_dec.shadow = w_k < K_CTRL;
    w_dec.ctrl   = w_k == K_CTRL;
    w_dec.stat0  = w_k == K_CTRL + 30'd1;
    w_dec.stat   = (w_k > K_CTRL) && (w_k <= K_LAST);
    w_dec.err    = !(w_dec.shadow || w_dec.ctrl || w_dec.stat) || (w_dec.stat && !OPB_RNW);
  end

  opb_slave_ack u_ack (
    .i_clk      (OPB_Clk),
    .i_rst      (OPB_Rst),
    .i_select   (OPB_select),
    .i_hit      (w_hit),
    .i_err      (w_dec.err),
    .o_start    (w_start),
    .o_xfer_ack (w_xfer_ack),
    .o_err_ack  (w_err_ack)
  );

  assign w_wr = w_start & ~OPB_RNW & ~w_dec.err;
  assign w_rd = w_start &  OPB_RNW & ~w_dec.err;

  always_comb begin
    w_ctrl = '0;
    w_ctrl[CTRL_CNT_LSB +: CNT_W] = r_cnt;
    w_ctrl[CTRL_AUTO]             = r_auto;
  end

  always_comb begin
    w_rdata = '0;
    for (int i = 0; i < NUM_REGS; i++)
      if (w_k == 30'(i)) w_rdata = r_shadow[i];
    if (w_dec.ctrl)  w_rdata = w_ctrl;
    if (w_dec.stat0) w_rdata = w_stat[0];
    for (int i = 1; i < NUM_STAT; i++)
      if (w_k == K_CTRL + 30'(i + 1)) w_rdata = r_snap[i];
  end

  // Commit is requested at the write's ack edge and applied one edge later,
  // so user_commit and the new user_data_out appear in the same cycle.
  always_ff @(posedge OPB_Clk) begin
    if (OPB_Rst) begin
      r_shadow     <= {NUM_REGS{RESET_VAL}};
      r_active     <= {NUM_REGS{RESET_VAL}};
      r_snap       <= '0;
      r_auto       <= 1'b0;
      r_cnt        <= '0;
      r_commit_req <= 1'b0;
      r_commit     <= 1'b0;
      r_rdata      <= '0;
    end else begin
      r_commit_req <= 1'b0;
      r_commit     <= r_commit_req;
      r_rdata      <= '0;
      if (r_commit_req) begin
        r_active <= r_shadow;
        r_cnt    <= r_cnt + 1'b1;
      end
      if (w_wr && w_dec.shadow && (w_be != '0)) begin
        for (int i = 0; i < NUM_REGS; i++)
          if (w_k == 30'(i)) r_shadow[i] <= (r_shadow[i] & ~w_mask) | (w_wdata & w_mask);
        r_commit_req <= r_auto;
      end
      if (w_wr && w_dec.ctrl && w_be[0]) begin
        r_auto       <= w_wdata[CTRL_AUTO];
        r_commit_req <= w_wdata[CTRL_COMMIT];
      end
      if (w_rd) begin
        r_rdata <= w_rdata;
        if (w_dec.stat0) r_snap <= w_stat;
      end
    end
  end

  // Leftmost-to-leftmost assignment puts fabric bit 31 on Sl_DBus[0].
  assign Sl_DBus       = r_rdata;
  assign Sl_xferAck    = w_xfer_ack;
  assign Sl_errAck     = w_err_ack;
  assign Sl_retry      = 1'b0;
  assign Sl_toutSup    = 1'b0;
  assign user_data_out = r_active;
  assign user_commit   = r_commit;

  assign w_unused = ^{OPB_seqAddr, w_off[1:0], r_snap[0], C_FAMILY[0],
                      C_OPB_AWIDTH[0], C_OPB_DWIDTH[0]};

endmodule

// File: tb/tb_opb_sw_reg_bank.sv
// Randomized bench for opb_sw_reg_bank against a word-level reference model.
module tb_opb_sw_reg_bank;

  localparam int          NR   = 4;
  localparam int          NS   = 2;
  localparam logic [31:0] BASE = 32'h0000_1000;
  localparam logic [31:0] HIGH = 32'h0000_10FF;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [0:31]     abus = '0;
  logic [0:31]     dbus = '0;
  logic [0:3]      be = '0;
  logic            rnw = 1'b0;
  logic            sel = 1'b0;
  logic            seq = 1'b0;
  logic [0:31]     sl_dbus;
  logic            sl_err, sl_retry, sl_tout, sl_xack;
  logic [NR*32-1:0] udo;
  logic            ucmt;
  logic [NS*32-1:0] udin = '0;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] m_sh[NR];
  logic [31:0] m_act[NR];
  logic [31:0] m_snap[NS];
  logic        m_auto;
  logic [15:0] m_cnt;

  always #5 clk = ~clk;

  opb_sw_reg_bank #(
    .C_BASEADDR(BASE), .C_HIGHADDR(HIGH), .C_OPB_AWIDTH(32), .C_OPB_DWIDTH(32),
    .C_FAMILY("virtex6"), .NUM_REGS(NR), .NUM_STAT(NS), .RESET_VAL(32'h0)
  ) dut (
    .OPB_Clk(clk), .OPB_Rst(rst), .OPB_ABus(abus), .OPB_BE(be), .OPB_DBus(dbus),
    .OPB_RNW(rnw), .OPB_select(sel), .OPB_seqAddr(seq),
    .Sl_DBus(sl_dbus), .Sl_errAck(sl_err), .Sl_retry(sl_retry), .Sl_toutSup(sl_tout),
    .Sl_xferAck(sl_xack), .user_data_out(udo), .user_commit(ucmt), .user_data_in(udin)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [NR*32-1:0] act_vec();
    logic [NR*32-1:0] r;
    for (int i = 0; i < NR; i++) r[32*i +: 32] = m_act[i];
    return r;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) begin m_sh[i] = '0; m_act[i] = '0; end
    for (int i = 0; i < NS; i++) m_snap[i] = '0;
    m_auto = 1'b0;
    m_cnt  = '0;
  endfunction

  // Called at #1 after an edge; returns at #1 after the cycle following the ack.
  task automatic xfer(input bit r, input int k, input logic [0:3] b, input logic [31:0] d,
                      output logic [31:0] rd);
    bit          err, cmt;
    logic [31:0] exp_rd;
    logic [NR*32-1:0] old_act;
    old_act = act_vec();
    err = (k > NR + NS) || (!r && k > NR);
    exp_rd = '0;
    cmt = 1'b0;
    if (!err) begin
      if (r) begin
        if (k < NR) exp_rd = m_sh[k];
        else if (k == NR) exp_rd = {m_cnt, 14'd0, m_auto, 1'b0};
        else if (k == NR + 1) begin
          exp_rd = udin[31:0];
          for (int j = 0; j < NS; j++) m_snap[j] = udin[32*j +: 32];
        end else exp_rd = m_snap[k - NR - 1];
      end else if (k < NR) begin
        if (b != 4'b0000) begin
          for (int j = 0; j < 4; j++)
            if (b[j]) m_sh[k][31 - 8*j -: 8] = d[31 - 8*j -: 8];
          cmt = m_auto;
        end
      end else if (b[3]) begin
        m_auto = d[1];
        cmt    = d[0];
      end
    end
    if (cmt) begin
      for (int i = 0; i < NR; i++) m_act[i] = m_sh[i];
      m_cnt = m_cnt + 16'd1;
    end
    abus = BASE + 32'(4 * k);
    dbus = d;
    be   = b;
    rnw  = r;
    sel  = 1'b1;
    @(posedge clk); #1;
    rd = sl_dbus;
    chk($sformatf("xack k=%0d r=%0d", k, r), sl_xack, !err);
    chk($sformatf("eack k=%0d r=%0d", k, r), sl_err, err);
    chk($sformatf("rdata k=%0d", k), sl_dbus, exp_rd);
    chk("uout_before", udo, old_act);
    chk("cmt_early", ucmt, 1'b0);
    sel = 1'b0;
    @(posedge clk); #1;
    chk("ack_single", {sl_xack, sl_err}, 2'b00);
    chk("dbus_idle", sl_dbus, 32'h0);
    chk($sformatf("commit k=%0d", k), ucmt, cmt);
    chk("uout_after", udo, act_vec());
  endtask

  logic [31:0] rd;
  int acks, first, nz;

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_xack", sl_xack, 1'b0);
    chk("rst_eack", sl_err, 1'b0);
    chk("rst_dbus", sl_dbus, 32'h0);
    chk("rst_cmt", ucmt, 1'b0);
    chk("rst_uout", udo, '0);
    chk("tied", {sl_retry, sl_tout}, 2'b00);
    rst = 1'b0;

    xfer(1, 0, 4'b1111, 32'h0, rd);
    xfer(0, 1, 4'b0101, 32'hDEADBEEF, rd);
    xfer(1, 1, 4'b1111, 32'h0, rd);
    chk("plan_k1", rd, 32'h00AD00EF);
    xfer(0, NR, 4'b1111, 32'h1, rd);
    chk("plan_word1", udo[63:32], 32'h00AD00EF);
    xfer(1, NR, 4'b1111, 32'h0, rd);
    chk("plan_ctrl1", rd, 32'h00010000);
    xfer(0, NR, 4'b1111, 32'h2, rd);
    xfer(0, 0, 4'b1111, 32'h12345678, rd);
    chk("plan_word0", udo[31:0], 32'h12345678);
    xfer(1, NR, 4'b1111, 32'h0, rd);
    chk("plan_ctrl2", rd, 32'h00020002);
    xfer(0, 2, 4'b0000, 32'hFFFFFFFF, rd);
    xfer(0, NR, 4'b1111, 32'h3, rd);

    udin = {32'hAAAA0001, 32'hBBBB0002};
    xfer(1, NR + 1, 4'b1111, 32'h0, rd);
    chk("plan_stat0", rd, 32'hBBBB0002);
    udin = {32'hCCCC0003, 32'hDDDD0004};
    xfer(1, NR + 2, 4'b1111, 32'h0, rd);
    chk("plan_stat1", rd, 32'hAAAA0001);

    xfer(0, NR + 1, 4'b1111, 32'h55555555, rd);
    xfer(0, NR + 2, 4'b1111, 32'h55555555, rd);
    xfer(1, NR + NS + 1, 4'b1111, 32'h0, rd);
    xfer(0, NR + NS + 1, 4'b1111, 32'h0, rd);
    xfer(1, NR + 2, 4'b1111, 32'h0, rd);
    xfer(1, 0, 4'b1111, 32'h0, rd);

    abus = BASE; rnw = 1'b1; sel = 1'b1;
    acks = 0; first = 0; nz = 0;
    for (int i = 1; i <= 5; i++) begin
      @(posedge clk); #1;
      if (sl_xack | sl_err) begin acks++; if (first == 0) first = i; end
      else if (sl_dbus != 0) nz++;
    end
    sel = 1'b0;
    chk("hold_acks", acks, 1);
    chk("hold_first", first, 1);
    chk("hold_dbus", nz, 0);
    @(posedge clk); #1;

    foreach (abus[i]) abus[i] = 1'b0;
    acks = 0; nz = 0;
    for (int t = 0; t < 2; t++) begin
      abus = (t == 0) ? HIGH + 32'd1 : BASE - 32'd4;
      sel = 1'b1;
      repeat (3) begin
        @(posedge clk); #1;
        acks += int'(sl_xack | sl_err);
        if (sl_dbus != 0) nz++;
      end
      sel = 1'b0;
      @(posedge clk); #1;
    end
    chk("oow_acks", acks, 0);
    chk("oow_dbus", nz, 0);

    abus = BASE; rnw = 1'b1; sel = 1'b1; rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_noack", {sl_xack, sl_err}, 2'b00);
    model_reset();
    rst = 1'b0;
    @(posedge clk); #1;
    chk("rst_held_ack", sl_xack, 1'b1);
    chk("rst_held_data", sl_dbus, 32'h0);
    chk("rst_uout2", udo, '0);
    sel = 1'b0;
    @(posedge clk); #1;

    for (int n = 0; n < 200; n++) begin
      int  k;
      bit  r;
      logic [0:3]  b;
      logic [31:0] d;
      if ($urandom_range(0, 7) == 0)
        for (int j = 0; j < NS; j++) udin[32*j +: 32] = $urandom;
      k = $urandom_range(0, NR + NS + 1);
      r = $urandom_range(0, 1) == 1;
      b = 4'($urandom_range(0, 15));
      d = $urandom;
      if (k == NR && !r) d[0] = ($urandom_range(0, 2) == 0);
      xfer(r, k, b, d, rd);
    end

    for (int i = 0; i <= NR; i++) xfer(1, i, 4'b1111, 32'h0, rd);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
